mcpu_mem_ltc_bram_mp: RTL and testbench
=======================================

Name: mcpu_mem_ltc_bram_mp

Overview:
- Next-generation LTC data/tag array: one byte-enabled write port, NREAD independent read ports, optional output register stage.
- Adds a hardware clear sweep after reset or on request, and write-to-read forwarding on address collision.
- Sits under the LTC controller, replacing the fixed dual-port array; the controller waits for init_done before issuing traffic.

Parameters:
- DEPTH, 512, number of entries.
- DEPTH_BITS, 9, address width; DEPTH must be at most 2**DEPTH_BITS.
- WIDTH_BYTES, 32, entry width in bytes; data width is WIDTH_BYTES*8.
- NREAD, 2, number of read ports (1..4).
- OUTREG, 0, 0 gives 1-cycle read latency; 1 adds an output register stage for 2-cycle latency.
- INIT_BYTE, 8'h00, byte value written to every byte during a clear sweep.

Ports:
- clkrst_mem_clk  in  1  memory clock.
- clkrst_mem_rst  in  1  asynchronous active-high reset.
- clr_req  in  1  single-cycle request to restart the clear sweep; honoured only in READY.
- init_done  out  1  high when in READY.
- waddr  in  DEPTH_BITS  write address.
- wbe  in  WIDTH_BYTES  per-byte write enable; all-zero means no write.
- wdata  in  WIDTH_BYTES*8  write data.
- wpar_inv  in  WIDTH_BYTES  parity-error injection, per byte.
- re  in  NREAD  per-port read enable.
- raddr  in  NREAD*DEPTH_BITS  port i address at [i*DEPTH_BITS +: DEPTH_BITS].
- rvalid  out  NREAD  per-port read data valid pulse.
- rdata  out  NREAD*WIDTH_BYTES*8  port i data at [i*W +: W], where W = WIDTH_BYTES*8.
- rperr  out  NREAD  per-port parity error, qualified by rvalid.

Behaviour:
- Reset (async, any time including mid-sweep):
  - FSM enters CLEAR with sweep counter = 0.
  - init_done=0, rvalid=0, rperr=0, rdata=0, all pipeline valid bits = 0.
  - RAM contents are not reset directly; the sweep overwrites them.
- FSM state CLEAR:
  - Each cycle writes INIT_BYTE to all bytes of entry[counter] with correct parity, then increments the counter.
  - After writing entry DEPTH-1, moves to READY on the next edge; CLEAR lasts exactly DEPTH cycles.
  - External wbe and re are ignored; no rvalid pulses.
  - clr_req is ignored.
- FSM state READY:
  - init_done=1.
  - clr_req=1 moves to CLEAR with counter=0 on the next edge. A write or read presented in that same cycle is still performed.
- Write: for each byte b with wbe[b]=1 in READY, entry[waddr] byte b is updated at the clock edge.
- Read: re[i]=1 in READY samples raddr[i].
  - OUTREG=0: rdata[i] and rvalid[i] are valid the following cycle.
  - OUTREG=1: valid two cycles later.
  - rvalid[i] is a one-cycle pulse per accepted read; back-to-back reads are accepted every cycle.
  - rdata[i] holds its last value when no read completes.
- Collision (raddr[i]==waddr in the same cycle as a write):
  - Returned data is per-byte merged: wdata bytes where wbe is set, old contents elsewhere. This is write-first behaviour.
  - Applies independently to every read port.
- Multiple read ports may hit the same address in the same cycle; each gets identical data.
- Addresses >= DEPTH give undefined data, but rvalid still pulses; no other side effects.
- rperr[i] is meaningful only when rvalid[i]=1 and is 0 otherwise.

Optional Feature:
- Macro: MCPU_MEM_LTC_BRAM_MP_PARITY_EN.
- Defined:
  - Each byte carries an even-parity bit, stored as parity(wdata byte) XOR wpar_inv[b].
  - On read, rperr[i]=1 if any returned byte's recomputed parity differs from its stored bit.
  - Forwarded bytes use the incoming byte's computed parity XOR wpar_inv.
  - Sweep writes correct parity.
- Undefined: no parity storage, rperr tied to 0, wpar_inv unused.

Test Plan:
- Assert reset for 3 cycles, release with DEPTH=512 -> init_done rises exactly 512 cycles after release; a read of address 0x1FF returns all bytes = INIT_BYTE and rperr=0.
- Write 0xAA.. to address 5 with wbe all ones, then wbe=0x0000_000F with data 0x55.. -> next read of port 0 at address 5 returns bytes 0..3 = 0x55, bytes 4..31 = 0xAA, with rvalid at +1 cycle (OUTREG=0) or +2 cycles (OUTREG=1).
- Same-cycle write to address 7 (wbe=0x1, data byte 0 = 0x3C) and reads on ports 0 and 1 of address 7 -> both return byte 0 = 0x3C, remaining bytes equal prior contents.
- Pulse clr_req in READY while writing address 9 -> init_done drops next cycle, re is ignored for 512 cycles, and address 9 reads INIT_BYTE afterwards.
- Assert reset 100 cycles into a sweep -> counter restarts, init_done stays 0 until 512 cycles after reset release.
- PARITY_EN: write address 3 with wpar_inv=0x2 -> read returns rperr=1 with rvalid; rewrite with wpar_inv=0 -> rperr=0. With the macro off, rperr stays 0.

Source files
------------

// File: rtl/mcpu_mem_ltc_bram_mp.sv
// ============================================================================
// Module   : mcpu_mem_ltc_bram_mp
// Purpose  : LTC data/tag array with one byte-enabled write port and NREAD
//            independent read ports. After reset, or when clr_req is pulsed,
//            the array runs a hardware clear sweep. A read that hits the
//            address being written in the same cycle returns the new bytes
//            (write-first). An optional output register stage is available.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clkrst_mem_clk / clkrst_mem_rst : clock, async active-high reset
//   clr_req                         : restart clear sweep (READY only)
//   init_done                       : high while the array is in READY
//   waddr / wbe / wdata / wpar_inv  : write port (byte enables, parity inject)
//   re / raddr                      : per-port read enable and address
//   rvalid / rdata / rperr          : per-port read response
// Optional feature:
//   MCPU_MEM_LTC_BRAM_MP_PARITY_EN  : per-byte even parity storage and check
// ============================================================================
`default_nettype none

module mcpu_mem_ltc_bram_mp #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned DEPTH_BITS  = 9,
    parameter int unsigned WIDTH_BYTES = 32,
    parameter int unsigned NREAD       = 2,
    parameter int unsigned OUTREG      = 0,
    parameter logic [7:0]  INIT_BYTE   = 8'h00
) (
    input  logic                                clkrst_mem_clk,
    input  logic                                clkrst_mem_rst,
    input  logic                                clr_req,
    output logic                                init_done,
    input  logic [DEPTH_BITS-1:0]               waddr,
    input  logic [WIDTH_BYTES-1:0]              wbe,
    input  logic [WIDTH_BYTES*8-1:0]            wdata,
    input  logic [WIDTH_BYTES-1:0]              wpar_inv,
    input  logic [NREAD-1:0]                    re,
    input  logic [NREAD*DEPTH_BITS-1:0]         raddr,
    output logic [NREAD-1:0]                    rvalid,
    output logic [NREAD*WIDTH_BYTES*8-1:0]      rdata,
    output logic [NREAD-1:0]                    rperr
);

    localparam int unsigned W = WIDTH_BYTES * 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_BITS-1:0] cnt_q, cnt_d;
    logic                  ready;
    logic                  sweep_last;
    logic                  wr_en;
    logic                  waddr_ok;

    assign ready      = (state_q == S_READY);
    assign init_done  = ready;
    assign sweep_last = (32'(cnt_q) == DEPTH - 1);
    assign wr_en      = ready && (|wbe);
    // Out-of-range writes are dropped so they cannot alias onto real entries.
    assign waddr_ok   = (32'(waddr) < DEPTH);

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (sweep_last) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DEPTH_BITS'(1);
                end
            end
            S_READY: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage (not reset; the sweep initialises it)
    // ------------------------------------------------------------------
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clkrst_mem_clk) begin
        if (!ready) begin
            mem_q[cnt_q] <= {WIDTH_BYTES{INIT_BYTE}};
        end else if (waddr_ok) begin
            for (int b = 0; b < int'(WIDTH_BYTES); b++) begin
                if (wbe[b]) begin
                    mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef MCPU_MEM_LTC_BRAM_MP_PARITY_EN
    logic [WIDTH_BYTES-1:0] par_q [DEPTH];

    always_ff @(posedge clkrst_mem_clk) begin
        if (!ready) begin
            par_q[cnt_q] <= {WIDTH_BYTES{^INIT_BYTE}};
        end else if (waddr_ok) begin
            for (int b = 0; b < int'(WIDTH_BYTES); b++) begin
                if (wbe[b]) begin
                    par_q[waddr][b] <= (^wdata[b*8 +: 8]) ^ wpar_inv[b];
                end
            end
        end
    end
`else
    logic unused_wpar;
    assign unused_wpar = ^wpar_inv;
`endif

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < int'(NREAD); gi++) begin : g_rport
        logic [DEPTH_BITS-1:0] addr;
        logic                  addr_ok;
        logic                  accept;
        logic                  hit;
        logic [W-1:0]          mrg_data;
        logic                  perr_d;
        logic [W-1:0]          rd1_q;
        logic                  rv1_q;
        logic                  pe1_q;

        assign addr    = raddr[gi*DEPTH_BITS +: DEPTH_BITS];
        assign addr_ok = (32'(addr) < DEPTH);
        assign accept  = ready && re[gi];
        assign hit     = wr_en && waddr_ok && (addr == waddr);

`ifdef MCPU_MEM_LTC_BRAM_MP_PARITY_EN
        logic [WIDTH_BYTES-1:0] mrg_par;

        always_comb begin
            mrg_data = addr_ok ? mem_q[addr] : '0;
            mrg_par  = addr_ok ? par_q[addr] : '0;
            perr_d   = 1'b0;
            // Write-first: bytes being written this cycle replace stale data.
            for (int b = 0; b < int'(WIDTH_BYTES); b++) begin
                if (hit && wbe[b]) begin
                    mrg_data[b*8 +: 8] = wdata[b*8 +: 8];
                    mrg_par[b]         = (^wdata[b*8 +: 8]) ^ wpar_inv[b];
                end
            end
            for (int b = 0; b < int'(WIDTH_BYTES); b++) begin
                if ((^mrg_data[b*8 +: 8]) != mrg_par[b]) begin
                    perr_d = 1'b1;
                end
            end
        end
`else
        always_comb begin
            mrg_data = addr_ok ? mem_q[addr] : '0;
            perr_d   = 1'b0;
            // Write-first: bytes being written this cycle replace stale data.
            for (int b = 0; b < int'(WIDTH_BYTES); b++) begin
                if (hit && wbe[b]) begin
                    mrg_data[b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
`endif

        // rd1_q only loads on an accepted read so rdata holds otherwise.
        always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
            if (clkrst_mem_rst) begin
                rd1_q <= '0;
                rv1_q <= 1'b0;
                pe1_q <= 1'b0;
            end else begin
                rv1_q <= accept;
                pe1_q <= accept & perr_d;
                if (accept) begin
                    rd1_q <= mrg_data;
                end
            end
        end

        if (OUTREG != 0) begin : g_oreg
            logic [W-1:0] rd2_q;
            logic         rv2_q;
            logic         pe2_q;

            always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
                if (clkrst_mem_rst) begin
                    rd2_q <= '0;
                    rv2_q <= 1'b0;
                    pe2_q <= 1'b0;
                end else begin
                    rv2_q <= rv1_q;
                    pe2_q <= rv1_q & pe1_q;
                    if (rv1_q) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign rdata[gi*W +: W] = rd2_q;
            assign rvalid[gi]       = rv2_q;
            assign rperr[gi]        = pe2_q;
        end else begin : g_noreg
            assign rdata[gi*W +: W] = rd1_q;
            assign rvalid[gi]       = rv1_q;
            assign rperr[gi]        = pe1_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mcpu_mem_ltc_bram_mp.sv
// ============================================================================
// Module   : tb_mcpu_mem_ltc_bram_mp
// Purpose  : Directed self-checking bench for mcpu_mem_ltc_bram_mp with
//            default parameters (DEPTH=512, 32-byte entries, 2 read ports,
//            OUTREG=0, INIT_BYTE=0). Parity expectations follow
//            MCPU_MEM_LTC_BRAM_MP_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_mem_ltc_bram_mp;

`ifdef MCPU_MEM_LTC_BRAM_MP_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr_req = 1'b0;
    logic         init_done;
    logic [8:0]   waddr = '0;
    logic [31:0]  wbe = '0;
    logic [255:0] wdata = '0;
    logic [31:0]  wpar_inv = '0;
    logic [1:0]   re = '0;
    logic [17:0]  raddr = '0;
    logic [1:0]   rvalid;
    logic [511:0] rdata;
    logic [1:0]   rperr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [255:0] exp5;
    logic [255:0] exp7;
    logic         seen_rv;
    logic         done_511;

    always #5 clk = ~clk;

    mcpu_mem_ltc_bram_mp dut (
        .clkrst_mem_clk (clk),
        .clkrst_mem_rst (rst),
        .clr_req        (clr_req),
        .init_done      (init_done),
        .waddr          (waddr),
        .wbe            (wbe),
        .wdata          (wdata),
        .wpar_inv       (wpar_inv),
        .re             (re),
        .raddr          (raddr),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .rperr          (rperr)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp5 = {{28{8'hAA}}, {4{8'h55}}};
        exp7 = {{31{8'h00}}, 8'h3C};

        // Reset for 3 cycles
        repeat (3) cyc();
        chk("rst_init_done", 512'(init_done), 512'(1'b0));
        chk("rst_rvalid",    512'(rvalid),    512'(2'b00));
        chk("rst_rdata",     rdata,           512'(0));
        chk("rst_rperr",     512'(rperr),     512'(2'b00));
        rst = 1'b0;

        // Sweep lasts exactly 512 cycles
        repeat (511) cyc();
        chk("sweep_511", 512'(init_done), 512'(1'b0));
        cyc();
        chk("sweep_512", 512'(init_done), 512'(1'b1));

        // Read cleared entries on both ports
        re = 2'b11;
        raddr = {9'h000, 9'h1FF};
        cyc();
        chk("clr_rvalid", 512'(rvalid), 512'(2'b11));
        chk("clr_rdata",  rdata,        512'(0));
        chk("clr_rperr",  512'(rperr),  512'(2'b00));

        // Full write then partial byte write to address 5
        re = 2'b00;
        waddr = 9'd5;
        wbe = 32'hFFFF_FFFF;
        wdata = {32{8'hAA}};
        cyc();
        chk("idle_rvalid", 512'(rvalid), 512'(2'b00));
        wbe = 32'h0000_000F;
        wdata = {32{8'h55}};
        cyc();
        wbe = '0;
        re = 2'b01;
        raddr = {9'h000, 9'd5};
        cyc();
        chk("be_rvalid", 512'(rvalid),   512'(2'b01));
        chk("be_rdata0", 512'(rdata[255:0]), 512'(exp5));

        // Collision: write addr 7 byte 0 while both ports read addr 7
        waddr = 9'd7;
        wbe = 32'h0000_0001;
        wdata = {{31{8'hFF}}, 8'h3C};
        re = 2'b11;
        raddr = {9'd7, 9'd7};
        cyc();
        chk("col_rvalid", 512'(rvalid), 512'(2'b11));
        chk("col_rdata0", 512'(rdata[255:0]),   512'(exp7));
        chk("col_rdata1", 512'(rdata[511:256]), 512'(exp7));

        // Back-to-back reads
        wbe = '0;
        raddr = {9'd7, 9'd5};
        cyc();
        chk("b2b1_rdata", rdata, {exp7, exp5});
        raddr = {9'd5, 9'd7};
        cyc();
        chk("b2b2_rdata", rdata, {exp5, exp7});
        chk("b2b2_rvalid", 512'(rvalid), 512'(2'b11));
        re = 2'b00;
        cyc();
        chk("hold_rvalid", 512'(rvalid), 512'(2'b00));
        chk("hold_rdata",  rdata,        {exp5, exp7});

        // Parity injection on address 3
        waddr = 9'd3;
        wbe = 32'hFFFF_FFFF;
        wdata = {32{8'h12}};
        wpar_inv = 32'h0000_0002;
        cyc();
        wbe = '0;
        wpar_inv = '0;
        re = 2'b01;
        raddr = {9'd0, 9'd3};
        cyc();
        chk("par_inj_rvalid", 512'(rvalid), 512'(2'b01));
        chk("par_inj_rperr",  512'(rperr),  512'({1'b0, PAR}));
        chk("par_inj_rdata",  512'(rdata[255:0]), 512'({32{8'h12}}));
        re = 2'b00;
        wbe = 32'hFFFF_FFFF;
        cyc();
        wbe = '0;
        re = 2'b01;
        cyc();
        chk("par_ok_rperr", 512'(rperr), 512'(2'b00));
        // Forwarded byte carries injected parity
        wbe = 32'h0000_0001;
        wdata = {{31{8'h12}}, 8'h34};
        wpar_inv = 32'h0000_0001;
        re = 2'b10;
        raddr = {9'd3, 9'd0};
        cyc();
        chk("par_fwd_rvalid", 512'(rvalid), 512'(2'b10));
        chk("par_fwd_rperr",  512'(rperr),  512'({PAR, 1'b0}));
        wbe = '0;
        wpar_inv = '0;
        re = 2'b00;

        // clr_req while writing address 9
        waddr = 9'd9;
        wbe = 32'hFFFF_FFFF;
        wdata = {32{8'h77}};
        clr_req = 1'b1;
        cyc();
        chk("clrreq_drop", 512'(init_done), 512'(1'b0));
        clr_req = 1'b0;
        wbe = '0;
        re = 2'b11;
        raddr = {9'd5, 9'd9};
        seen_rv = 1'b0;
        done_511 = 1'b1;
        for (int j = 1; j <= 512; j++) begin
            cyc();
            seen_rv = seen_rv | (|rvalid);
            if (j == 511) done_511 = init_done;
        end
        chk("clrreq_no_rvalid", 512'(seen_rv),   512'(1'b0));
        chk("clrreq_511",       512'(done_511),  512'(1'b0));
        chk("clrreq_512",       512'(init_done), 512'(1'b1));
        cyc();
        chk("clrreq_rvalid", 512'(rvalid), 512'(2'b11));
        chk("clrreq_rdata",  rdata,        512'(0));
        re = 2'b00;

        // Reset 100 cycles into a sweep restarts the counter
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (100) cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (511) cyc();
        chk("midrst_511", 512'(init_done), 512'(1'b0));
        cyc();
        chk("midrst_512", 512'(init_done), 512'(1'b1));

        // Asynchronous reset from READY with non-zero rdata
        waddr = 9'd1;
        wbe = 32'hFFFF_FFFF;
        wdata = {32{8'hAB}};
        cyc();
        wbe = '0;
        re = 2'b01;
        raddr = {9'd0, 9'd1};
        cyc();
        chk("pre_arst_rdata", 512'(rdata[255:0]), 512'({32{8'hAB}}));
        re = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_init_done", 512'(init_done), 512'(1'b0));
        chk("arst_rdata",     rdata,           512'(0));
        cyc();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
